// File: rtl/branch_pkg.sv
// branch_pkg: shared types and helpers for the branch sequencer.
//   state_e      - sequencer FSM states
//   BRZR..BRMI   - legal branch condition codes; BR_MAX is the highest legal code
//   sext_to_32() - sign-extend the low 'width' bits of a 32-bit word
package branch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StStrobe,
    StSettle,
    StResolve,
    StDone
  } state_e;

  localparam logic [3:0] BRZR   = 4'd0;
  localparam logic [3:0] BRNZ   = 4'd1;
  localparam logic [3:0] BRPL   = 4'd2;
  localparam logic [3:0] BRMI   = 4'd3;
  localparam logic [3:0] BR_MAX = 4'd3;

  // Shift the field up to bit 31, then arithmetic-shift back down to replicate its sign bit.
  function automatic logic [31:0] sext_to_32(input logic [31:0] value, input int unsigned width);
    logic [31:0] shifted;
    shifted = value << (32 - width);
    return $signed(shifted) >>> (32 - width);
  endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: decoder/condition-logic side of the branch sequencer.
//   Requests : start, c2, c_imm, pc_plus1, cond_met      (master -> slave)
//   Results  : bus_ra_out, con_in, pc_load, pc_next, busy,
//              done, taken, illegal, taken_count          (slave -> master)
// The sequencer itself connects through the slave modport.
interface branch_sequencer_if #(
  parameter int unsigned IMM_W   = 19,
  parameter int unsigned COUNT_W = 16
);

  logic               start;
  logic [3:0]         c2;
  logic [IMM_W-1:0]   c_imm;
  logic [31:0]        pc_plus1;
  logic               cond_met;

  logic               bus_ra_out;
  logic               con_in;
  logic               pc_load;
  logic [31:0]        pc_next;
  logic               busy;
  logic               done;
  logic               taken;
  logic               illegal;
  logic [COUNT_W-1:0] taken_count;

  modport master (
    output start, c2, c_imm, pc_plus1, cond_met,
    input  bus_ra_out, con_in, pc_load, pc_next, busy, done, taken, illegal, taken_count
  );

  modport slave (
    input  start, c2, c_imm, pc_plus1, cond_met,
    output bus_ra_out, con_in, pc_load, pc_next, busy, done, taken, illegal, taken_count
  );

endinterface

// File: rtl/branch_target_adder.sv
// branch_target_adder: combinational branch target, i_base + sext(i_imm), modulo 2^32.
//   i_base   - already-incremented PC
//   i_imm    - signed IMM_W-bit branch offset
//   o_target - branch target address
module branch_target_adder
  import branch_pkg::*;
#(
  parameter int unsigned IMM_W = 19
) (
  input  logic [31:0]      i_base,
  input  logic [IMM_W-1:0] i_imm,
  output logic [31:0]      o_target
);

  assign o_target = i_base + sext_to_32(32'(i_imm), IMM_W);

endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: initiator side of the branch-condition interface.
// On start it drives rA onto the bus, strobes the condition flip-flop, waits SETTLE_CYCLES,
// then samples cond_met and updates the PC (target if taken, else PC+1).
//   clock - system clock, posedge
//   clear - synchronous active-low reset
//   bus   - branch_sequencer_if.slave (request fields in; strobes, PC update, status out)
// SETTLE_CYCLES must lie in 1..15.
module branch_sequencer
  import branch_pkg::*;
#(
  parameter int unsigned IMM_W         = 19,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned COUNT_W       = 16
) (
  input logic               clock,
  input logic               clear,
  branch_sequencer_if.slave bus
);

  state_e             r_state;
  state_e             w_state_next;

  logic [3:0]         r_c2;
  logic [IMM_W-1:0]   r_imm;
  logic [31:0]        r_pc_plus1;
  logic [31:0]        r_pc_next;
  logic               r_taken;
  logic [3:0]         r_settle;
  logic [COUNT_W-1:0] r_count;

  logic [31:0]        w_target;
  logic [31:0]        w_pc_resolved;
  logic               w_accept;

  branch_target_adder #(
    .IMM_W (IMM_W)
  ) u_target_adder (
    .i_base   (r_pc_plus1),
    .i_imm    (r_imm),
    .o_target (w_target)
  );

  assign w_accept      = (r_state == StIdle) && bus.start;
  assign w_pc_resolved = bus.cond_met ? w_target : r_pc_plus1;

  // Next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          // Illegal codes skip the bus sequence entirely and report straight away.
          w_state_next = (bus.c2 <= BR_MAX) ? StDrive : StDone;
        end
      end
      StDrive:   w_state_next = StStrobe;
      StStrobe:  w_state_next = StSettle;
      StSettle: begin
        if (r_settle <= 4'd1) begin
          w_state_next = StResolve;
        end
      end
      StResolve: w_state_next = StDone;
      StDone:    w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // Outputs, decoded from the registered state
  always_comb begin
    bus.bus_ra_out  = 1'b0;
    bus.con_in      = 1'b0;
    bus.pc_load     = 1'b0;
    bus.pc_next     = r_pc_next;
    bus.busy        = (r_state != StIdle);
    bus.done        = 1'b0;
    bus.taken       = 1'b0;
    bus.illegal     = 1'b0;
    bus.taken_count = r_count;
    unique case (r_state)
      StIdle: ;
      StDrive: bus.bus_ra_out = 1'b1;
      StStrobe: begin
        bus.bus_ra_out = 1'b1;
        bus.con_in     = 1'b1;
      end
      StSettle: bus.bus_ra_out = 1'b1;
      StResolve: begin
        // cond_met comes from a register, so presenting the resolved PC now is glitch-safe.
        bus.pc_next = w_pc_resolved;
        bus.pc_load = bus.cond_met;
      end
      StDone: begin
        bus.done    = 1'b1;
        bus.taken   = r_taken;
        bus.illegal = (r_c2 > BR_MAX);
      end
      default: ;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state    <= StIdle;
      r_c2       <= '0;
      r_imm      <= '0;
      r_pc_plus1 <= '0;
      r_pc_next  <= '0;
      r_taken    <= 1'b0;
      r_settle   <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        r_c2       <= bus.c2;
        r_imm      <= bus.c_imm;
        r_pc_plus1 <= bus.pc_plus1;
        r_taken    <= 1'b0;
      end

      if (r_state == StStrobe) begin
        r_settle <= 4'(SETTLE_CYCLES);
      end else if (r_state == StSettle) begin
        r_settle <= r_settle - 4'd1;
      end

      if (r_state == StResolve) begin
        r_pc_next <= w_pc_resolved;
        r_taken   <= bus.cond_met;
        if (bus.cond_met && (r_count != {COUNT_W{1'b1}})) begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: two instances (SETTLE_CYCLES=1/COUNT_W=16 and
// SETTLE_CYCLES=3/COUNT_W=2) share one stimulus stream; each is compared every cycle against
// a transaction-level model of latency, PC update and saturating counter.
module tb_branch_sequencer;

  localparam int unsigned IW  = 19;
  localparam int unsigned SA  = 1;
  localparam int unsigned SB  = 3;
  localparam int unsigned CWA = 16;
  localparam int unsigned CWB = 2;
  localparam int unsigned MAXA = (1 << CWA) - 1;
  localparam int unsigned MAXB = (1 << CWB) - 1;

  logic          clk = 1'b0;
  logic          clear;
  logic          start;
  logic [3:0]    c2;
  logic [IW-1:0] c_imm;
  logic [31:0]   pc_plus1;
  logic          cond_met;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state shared across transactions
  logic [31:0] m_pc;
  int unsigned m_cnt_a;
  int unsigned m_cnt_b;

  always #5 clk = ~clk;

  branch_sequencer_if #(.IMM_W(IW), .COUNT_W(CWA)) bus_a ();
  branch_sequencer_if #(.IMM_W(IW), .COUNT_W(CWB)) bus_b ();

  assign bus_a.start    = start;
  assign bus_a.c2       = c2;
  assign bus_a.c_imm    = c_imm;
  assign bus_a.pc_plus1 = pc_plus1;
  assign bus_a.cond_met = cond_met;
  assign bus_b.start    = start;
  assign bus_b.c2       = c2;
  assign bus_b.c_imm    = c_imm;
  assign bus_b.pc_plus1 = pc_plus1;
  assign bus_b.cond_met = cond_met;

  branch_sequencer #(.IMM_W(IW), .SETTLE_CYCLES(SA), .COUNT_W(CWA)) dut_a (
    .clock (clk),
    .clear (clear),
    .bus   (bus_a)
  );

  branch_sequencer #(.IMM_W(IW), .SETTLE_CYCLES(SB), .COUNT_W(CWB)) dut_b (
    .clock (clk),
    .clear (clear),
    .bus   (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs in cycle k after the start edge: RESOLVE at s+3, done at s+4 (legal),
  // done at 1 (illegal); beyond done the block is idle.
  task automatic check_dut(input string dn, input int k, input int s, input bit legal,
                           input bit cond, input logic [31:0] pc_before, input logic [31:0] pc_after,
                           input int unsigned cnt_before, input int unsigned cnt_after,
                           input logic ra, input logic ci, input logic pl, input logic [31:0] pn,
                           input logic bz, input logic dn_o, input logic tk, input logic il,
                           input logic [31:0] cnt);
    int r;
    int d;
    string p;
    r = s + 3;
    d = legal ? s + 4 : 1;
    p = $sformatf("%s.c%0d.", dn, k);
    chk({p, "bus_ra_out"}, 32'(ra), 32'(legal && k < r));
    chk({p, "con_in"}, 32'(ci), 32'(legal && k == 2));
    chk({p, "pc_load"}, 32'(pl), 32'(legal && cond && k == r));
    chk({p, "pc_next"}, pn, (legal && k >= r) ? pc_after : pc_before);
    chk({p, "busy"}, 32'(bz), 32'(k <= d));
    chk({p, "done"}, 32'(dn_o), 32'(k == d));
    chk({p, "taken"}, 32'(tk), 32'(k == d && legal && cond));
    chk({p, "illegal"}, 32'(il), 32'(k == d && !legal));
    chk({p, "taken_count"}, cnt, (k >= d) ? cnt_after : cnt_before);
  endtask

  task automatic check_all(input int k, input bit legal, input bit cond,
                           input logic [31:0] pc_before, input logic [31:0] pc_after,
                           input int unsigned ca0, input int unsigned ca1,
                           input int unsigned cb0, input int unsigned cb1);
    check_dut("a", k, SA, legal, cond, pc_before, pc_after, ca0, ca1,
              bus_a.bus_ra_out, bus_a.con_in, bus_a.pc_load, bus_a.pc_next, bus_a.busy,
              bus_a.done, bus_a.taken, bus_a.illegal, 32'(bus_a.taken_count));
    check_dut("b", k, SB, legal, cond, pc_before, pc_after, cb0, cb1,
              bus_b.bus_ra_out, bus_b.con_in, bus_b.pc_load, bus_b.pc_next, bus_b.busy,
              bus_b.done, bus_b.taken, bus_b.illegal, 32'(bus_b.taken_count));
  endtask

  // Called at a negedge; issues one request and checks every cycle until both blocks idle.
  // poke != 0 raises start again (with junk fields) in that cycle, which must be ignored.
  task automatic run_txn(input logic [3:0] cc, input logic [IW-1:0] imm, input logic [31:0] pc,
                         input bit cond, input int poke);
    bit legal;
    int off;
    int dmax;
    logic [31:0] pc_after;
    int unsigned ca1;
    int unsigned cb1;
    legal = (cc <= 4'd3);
    off = int'(imm);
    if (imm[IW-1]) off = off - (1 << IW);
    pc_after = legal ? (cond ? pc + 32'(off) : pc) : m_pc;
    ca1 = (legal && cond && m_cnt_a < MAXA) ? m_cnt_a + 1 : m_cnt_a;
    cb1 = (legal && cond && m_cnt_b < MAXB) ? m_cnt_b + 1 : m_cnt_b;
    dmax = legal ? int'(SB) + 4 : 1;

    c2 = cc;
    c_imm = imm;
    pc_plus1 = pc;
    cond_met = cond;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= dmax + 1; k++) begin
      @(negedge clk);
      check_all(k, legal, cond, m_pc, pc_after, m_cnt_a, ca1, m_cnt_b, cb1);
      if (k == poke) begin
        start = 1'b1;
        c2 = 4'($urandom_range(0, 3));
        c_imm = IW'($urandom);
        pc_plus1 = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    m_pc = pc_after;
    m_cnt_a = ca1;
    m_cnt_b = cb1;
  endtask

  // Starts a legal branch and pulls clear low during SETTLE; nothing must be loaded.
  task automatic run_abort(input logic [IW-1:0] imm, input logic [31:0] pc);
    c2 = 4'd0;
    c_imm = imm;
    pc_plus1 = pc;
    cond_met = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_all(k, 1'b1, 1'b1, m_pc, m_pc, m_cnt_a, m_cnt_a, m_cnt_b, m_cnt_b);
    end
    clear = 1'b0;
    @(negedge clk);
    m_pc = '0;
    m_cnt_a = 0;
    m_cnt_b = 0;
    // Large cycle index means "idle, long after any transaction".
    check_all(100, 1'b1, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0);
    clear = 1'b1;
  endtask

  initial begin
    logic [3:0] rc;
    clear = 1'b0;
    start = 1'b0;
    c2 = '0;
    c_imm = '0;
    pc_plus1 = '0;
    cond_met = 1'b0;
    m_pc = '0;
    m_cnt_a = 0;
    m_cnt_b = 0;
    repeat (2) @(negedge clk);
    check_all(100, 1'b1, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0);
    clear = 1'b1;

    run_txn(4'd0, 19'h00010, 32'h0000_0100, 1'b1, 0);   // taken -> 0x110
    run_txn(4'd1, 19'h01234, 32'h0000_0200, 1'b0, 0);   // not taken -> 0x200
    run_txn(4'd2, 19'h7FFF8, 32'h0000_0005, 1'b1, 0);   // -8 wraps -> 0xFFFFFFFD
    run_txn(4'd5, 19'h00040, 32'h0000_0300, 1'b1, 0);   // illegal code
    run_txn(4'd3, 19'h00040, 32'h0000_1000, 1'b1, 3);   // second start while busy
    run_abort(19'h00020, 32'h0000_4000);
    run_txn(4'd0, 19'h00008, 32'h0000_0800, 1'b1, 0);   // fresh start after abort

    for (int i = 0; i < 5; i++) begin
      run_txn(4'd2, IW'($urandom), $urandom, 1'b1, 0);  // drives the 2-bit counter to 3
    end

    for (int i = 0; i < 20; i++) begin
      rc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      run_txn(rc, IW'($urandom), $urandom, 1'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Initiator side of the branch-condition interface. On a decoded branch instruction it places rA on the bus, strobes the condition flip-flop with con_in, and waits for the result to settle.
- It then samples cond_met and drives the PC update: the branch target if the condition holds, otherwise PC+1.
- Sits in the control unit between the instruction decoder and the PC register.
- Also keeps a saturating count of taken branches for debug.

Parameters:
- IMM_W, 19, width of the C-field branch offset (sign-extended to 32).
- SETTLE_CYCLES, 1, cycles waited after the con_in strobe before sampling cond_met (range 1..15).
- COUNT_W, 16, width of the taken-branch counter.

Ports:
- clock  in  1  system clock; all logic on posedge.
- clear  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request from the decoder; valid branch fields present.
- c2  in  4  branch condition code.
- c_imm  in  IMM_W  signed branch offset.
- pc_plus1  in  32  already-incremented PC.
- cond_met  in  1  registered condition result from the condition flip-flop.
- bus_ra_out  out  1  request to drive rA onto the bus.
- con_in  out  1  condition flip-flop load strobe.
- pc_load  out  1  PC write enable.
- pc_next  out  32  value to load into PC.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- taken  out  1  qualifies done: branch was taken.
- illegal  out  1  qualifies done: c2 was not a branch code.
- taken_count  out  COUNT_W  saturating count of taken branches.

Behaviour:
- Reset: when clear=0 at posedge, state=IDLE. All outputs go to 0, including pc_next and taken_count. Captured fields are cleared. Reset applies from any state and abandons a branch in progress with no pc_load.
- Outputs are Moore, decoded from registered state. con_in is never high in the same cycle bus_ra_out first rises.
- Condition codes: 0=BRZR, 1=BRNZ, 2=BRPL, 3=BRMI. Codes 4..15 are illegal.
- States:
  - IDLE: if start=1, capture c2, c_imm and pc_plus1. If c2<=3 go to DRIVE; otherwise go to DONE with illegal set. start is ignored in every other state; there is no queuing.
  - DRIVE: bus_ra_out=1, con_in=0. Next state is STROBE.
  - STROBE: bus_ra_out=1, con_in=1 for exactly one cycle. Next state is SETTLE.
  - SETTLE: bus_ra_out=1, con_in=0. Counter loads SETTLE_CYCLES and decrements; exit to RESOLVE when it reaches 0. Total time in SETTLE is SETTLE_CYCLES cycles.
  - RESOLVE: sample cond_met.
    - If 1: pc_next = pc_plus1 + sext(c_imm), mod 2^32; pc_load=1 for this cycle; set taken; increment taken_count, saturating at all-ones.
    - If 0: pc_next = pc_plus1; pc_load=0.
    - Next state is DONE.
  - DONE: done=1. taken/illegal are valid this cycle only. Next state is IDLE.
- pc_next holds its value after RESOLVE until the next RESOLVE or reset.
- Latency (SETTLE_CYCLES=1), start sampled at edge 0:
  - DRIVE in cycle 1, STROBE in cycle 2, SETTLE in cycle 3.
  - RESOLVE and pc_load in cycle 4, done in cycle 5.
  - Illegal code: done in cycle 1.
- Back-to-back: start may be accepted in the cycle after DONE, when the state is IDLE.

Decomposition:
- Shared package (branch_pkg):
  - State enum: IDLE, DRIVE, STROBE, SETTLE, RESOLVE, DONE.
  - Condition-code constants BRZR, BRNZ, BRPL, BRMI, plus BR_MAX=3.
  - Sign-extension function for IMM_W to 32.
- One sub-module, branch_target_adder: combinational sign-extend plus 32-bit add. Everything else stays in the top FSM.

Test Plan:
- Taken branch: c2=0, pc_plus1=0x100, c_imm=0x00010, cond_met=1 at RESOLVE -> con_in high cycle 2 only; pc_load=1 and pc_next=0x110 in cycle 4; done=1 and taken=1 in cycle 5; taken_count=1.
- Not taken: c2=1, pc_plus1=0x200, cond_met=0 -> pc_load stays 0, pc_next=0x200, done in cycle 5 with taken=0, taken_count unchanged.
- Negative offset with wrap: pc_plus1=0x5, c_imm=0x7FFF8 (-8), cond_met=1 -> pc_next=0xFFFFFFFD.
- Illegal code: c2=4'b0101 -> done=1 and illegal=1 in cycle 1; bus_ra_out, con_in and pc_load never assert.
- Busy and reset: second start during SETTLE is ignored, with exactly one done pulse. Then clear=0 during SETTLE -> next cycle IDLE, all outputs 0, no pc_load; a fresh start completes normally.
- Parameter sweep:
  - SETTLE_CYCLES=3 -> RESOLVE in cycle 6.
  - COUNT_W=2 with five taken branches -> taken_count saturates at 3.
